// File: rtl/usb_packet_rx.sv
// usb_packet_rx: byte-level USB packet decoder (token/SOF, data, handshake) with CRC5 check.
// Define USB_PACKET_RX_CRC16_EN to compile in the CRC16 check on data packets.
module usb_packet_rx #(
  parameter int MAX_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_active,
  input  logic        rx_valid,
  input  logic        rx_error,
  output logic [3:0]  pid,
  output logic [6:0]  addr,
  output logic [3:0]  endp,
  output logic [10:0] frame,
  output logic        token_valid,
  output logic [7:0]  data_byte,
  output logic        data_valid,
  output logic        packet_done,
  output logic        packet_ok,
  output logic [2:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_TOKEN, S_DATA, S_HSK, S_DRAIN
  } state_t;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_PID   = 3'd1;
  localparam logic [2:0] E_CRC5  = 3'd2;
  localparam logic [2:0] E_LEN   = 3'd4;
  localparam logic [2:0] E_RXERR = 3'd5;
`ifdef USB_PACKET_RX_CRC16_EN
  localparam logic [2:0] E_CRC16 = 3'd3;
`endif

  localparam int            CW       = 11;
  localparam logic [CW-1:0] CNT_SAT  = '1;
  localparam logic [CW-1:0] EMIT_LIM = CW'(MAX_BYTES + 2);
  localparam logic [3:0]    PID_SOF  = 4'b0101;

  // Serial CRCs, data bits taken LSB first, register shifting toward its MSB.
  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] b);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (b[i] ^ r[4]) r = {r[3:0], 1'b0} ^ 5'h05;
      else             r = {r[3:0], 1'b0};
    end
    return r;
  endfunction

`ifdef USB_PACKET_RX_CRC16_EN
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (b[i] ^ r[15]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction
`endif

  function automatic logic [2:0] first_err(input logic [2:0] cur, input logic [2:0] nw);
    return (cur == E_NONE) ? nw : cur;
  endfunction

  state_t        state_q, state_d;
  logic          act_q, act_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    err_q, err_d;
  logic [3:0]    tpid_q, tpid_d;
  logic [7:0]    b1_q, b1_d;
  logic [7:0]    b2_q, b2_d;
  logic [4:0]    crc5_q, crc5_d;
`ifdef USB_PACKET_RX_CRC16_EN
  logic [15:0]   crc16_q, crc16_d;
`endif
  logic [3:0]    pid_q, pid_d;
  logic [6:0]    addr_q, addr_d;
  logic [3:0]    endp_q, endp_d;
  logic [10:0]   frame_q, frame_d;
  logic          token_valid_q, token_valid_d;
  logic [7:0]    data_byte_q, data_byte_d;
  logic          data_valid_q, data_valid_d;
  logic          packet_done_q, packet_done_d;
  logic          packet_ok_q, packet_ok_d;
  logic [2:0]    err_code_q, err_code_d;
  logic [2:0]    fin_err;

  always_comb begin
    state_d       = state_q;
    act_d         = rx_active;
    cnt_d         = cnt_q;
    err_d         = err_q;
    tpid_d        = tpid_q;
    b1_d          = b1_q;
    b2_d          = b2_q;
    crc5_d        = crc5_q;
`ifdef USB_PACKET_RX_CRC16_EN
    crc16_d       = crc16_q;
`endif
    pid_d         = pid_q;
    addr_d        = addr_q;
    endp_d        = endp_q;
    frame_d       = frame_q;
    token_valid_d = 1'b0;
    data_byte_d   = data_byte_q;
    data_valid_d  = 1'b0;
    packet_done_d = 1'b0;
    packet_ok_d   = packet_ok_q;
    err_code_d    = err_code_q;
    fin_err       = err_q;

    if (state_q == S_IDLE) begin
      if (rx_active && !act_q) begin
        state_d = S_PID;
        cnt_d   = '0;
        err_d   = E_NONE;
        crc5_d  = '1;
`ifdef USB_PACKET_RX_CRC16_EN
        crc16_d = '1;
`endif
      end
    end else if (!rx_active) begin
      // End of packet: resolve end-of-packet checks unless an earlier error is held.
      case (state_q)
        S_PID:   fin_err = E_PID;
        S_TOKEN: begin
          if (err_q == E_NONE) begin
            if (cnt_q != CW'(2))          fin_err = E_LEN;
            else if (crc5_q != 5'b01100) fin_err = E_CRC5;
          end
        end
        S_DATA: begin
          if (err_q == E_NONE) begin
            if (cnt_q < CW'(2))            fin_err = E_LEN;
`ifdef USB_PACKET_RX_CRC16_EN
            else if (crc16_q != 16'h800D) fin_err = E_CRC16;
`endif
          end
        end
        default: ;
      endcase
      packet_done_d = 1'b1;
      packet_ok_d   = (fin_err == E_NONE);
      err_code_d    = fin_err;
      if (state_q == S_TOKEN && fin_err == E_NONE) begin
        token_valid_d = 1'b1;
        if (tpid_q == PID_SOF) begin
          frame_d = {b2_q[2:0], b1_q};
        end else begin
          addr_d = b1_q[6:0];
          endp_d = {b2_q[2:0], b1_q[7]};
        end
      end
      state_d = S_IDLE;
    end else if (rx_error) begin
      err_d   = E_RXERR;
      state_d = S_DRAIN;
    end else if (rx_valid) begin
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
      case (state_q)
        S_PID: begin
          cnt_d = '0;
          if (rx_data[7:4] != ~rx_data[3:0]) begin
            err_d   = E_PID;
            state_d = S_DRAIN;
          end else begin
            tpid_d = rx_data[3:0];
            case (rx_data[1:0])
              2'b01:   begin pid_d = rx_data[3:0]; state_d = S_TOKEN; end
              2'b11:   begin pid_d = rx_data[3:0]; state_d = S_DATA;  end
              2'b10:   begin pid_d = rx_data[3:0]; state_d = S_HSK;   end
              default: begin err_d = E_PID;        state_d = S_DRAIN; end
            endcase
          end
        end
        S_TOKEN: begin
          if (cnt_q == CW'(0)) b1_d = rx_data;
          if (cnt_q == CW'(1)) b2_d = rx_data;
          if (cnt_q < CW'(2))  crc5_d = crc5_byte(crc5_q, rx_data);
        end
        S_DATA: begin
`ifdef USB_PACKET_RX_CRC16_EN
          crc16_d = crc16_byte(crc16_q, rx_data);
`endif
          // Two-byte delay line keeps the trailing CRC16 off data_byte.
          if (cnt_q >= CW'(2)) begin
            if (cnt_q < EMIT_LIM) begin
              data_byte_d  = b1_q;
              data_valid_d = 1'b1;
            end else begin
              err_d = first_err(err_q, E_LEN);
            end
          end
          b1_d = b2_q;
          b2_d = rx_data;
        end
        S_HSK:   err_d = first_err(err_q, E_LEN);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      // Held high so a packet already in flight at reset release is not mistaken for a new one.
      act_q         <= 1'b1;
      cnt_q         <= '0;
      err_q         <= E_NONE;
      tpid_q        <= '0;
      b1_q          <= '0;
      b2_q          <= '0;
      crc5_q        <= '1;
`ifdef USB_PACKET_RX_CRC16_EN
      crc16_q       <= '1;
`endif
      pid_q         <= '0;
      addr_q        <= '0;
      endp_q        <= '0;
      frame_q       <= '0;
      token_valid_q <= 1'b0;
      data_byte_q   <= '0;
      data_valid_q  <= 1'b0;
      packet_done_q <= 1'b0;
      packet_ok_q   <= 1'b0;
      err_code_q    <= E_NONE;
    end else begin
      state_q       <= state_d;
      act_q         <= act_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      tpid_q        <= tpid_d;
      b1_q          <= b1_d;
      b2_q          <= b2_d;
      crc5_q        <= crc5_d;
`ifdef USB_PACKET_RX_CRC16_EN
      crc16_q       <= crc16_d;
`endif
      pid_q         <= pid_d;
      addr_q        <= addr_d;
      endp_q        <= endp_d;
      frame_q       <= frame_d;
      token_valid_q <= token_valid_d;
      data_byte_q   <= data_byte_d;
      data_valid_q  <= data_valid_d;
      packet_done_q <= packet_done_d;
      packet_ok_q   <= packet_ok_d;
      err_code_q    <= err_code_d;
    end
  end

  assign pid         = pid_q;
  assign addr        = addr_q;
  assign endp        = endp_q;
  assign frame       = frame_q;
  assign token_valid = token_valid_q;
  assign data_byte   = data_byte_q;
  assign data_valid  = data_valid_q;
  assign packet_done = packet_done_q;
  assign packet_ok   = packet_ok_q;
  assign err_code    = err_code_q;

endmodule
